// File: rtl/score_keeper.sv
// score_keeper: match-state and scoring controller for Pong.
// Counts goals per player, paces play with a post-point pause, issues
// serve pulses and latches the winner until a new match is started.
module score_keeper #(
  parameter int WIN_SCORE    = 11,
  parameter int WIN_MARGIN   = 2,
  parameter int PAUSE_CYCLES = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       GOAL1,
  input  logic       GOAL2,
  input  logic       NEW_GAME,
  output logic [4:0] Score1,
  output logic [4:0] Score2,
  output logic       WIN1,
  output logic       WIN2,
  output logic       PAUSED,
  output logic       SERVE,
  output logic       SERVE_DIR
);

  localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [5:0] WIN_SCORE_W  = 6'(WIN_SCORE);
  localparam logic [5:0] WIN_MARGIN_W = 6'(WIN_MARGIN);

  typedef enum logic [1:0] {
    S_PAUSE,
    S_PLAY,
    S_OVER
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       score1_nx, score2_nx;
  logic             win1_nx, win2_nx, paused_nx, serve_nx, dir_nx;
  logic             ng_q, ng_armed, ng_edge;
  logic             goal_one, goal_two;
  logic [4:0]       inc1, inc2;
  logic             p1_wins, p2_wins;

  // A player wins with enough points and a sufficient lead, or by maxing out the score.
  function automatic logic wins(input logic [4:0] s, input logic [4:0] o);
    logic [5:0] diff;
    diff = {1'b0, s} - {1'b0, o};
    return (({1'b0, s} >= WIN_SCORE_W) && (s >= o) && (diff >= WIN_MARGIN_W))
           || (s == 5'd31);
  endfunction

  // ng_armed blocks an edge from a NEW_GAME level that was already high at reset release.
  assign ng_edge  = NEW_GAME & ~ng_q & ng_armed;
  assign goal_one = GOAL1 & ~GOAL2;
  assign goal_two = GOAL2 & ~GOAL1;
  assign inc1     = (Score1 == 5'd31) ? Score1 : Score1 + 5'd1;
  assign inc2     = (Score2 == 5'd31) ? Score2 : Score2 + 5'd1;
  assign p1_wins  = wins(inc1, Score2);
  assign p2_wins  = wins(inc2, Score1);

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_PAUSE;
      cnt       <= '0;
      Score1    <= '0;
      Score2    <= '0;
      WIN1      <= 1'b0;
      WIN2      <= 1'b0;
      PAUSED    <= 1'b1;
      SERVE     <= 1'b0;
      SERVE_DIR <= 1'b0;
      ng_q      <= 1'b0;
      ng_armed  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      Score1    <= score1_nx;
      Score2    <= score2_nx;
      WIN1      <= win1_nx;
      WIN2      <= win2_nx;
      PAUSED    <= paused_nx;
      SERVE     <= serve_nx;
      SERVE_DIR <= dir_nx;
      ng_q      <= NEW_GAME;
      if (!NEW_GAME) ng_armed <= 1'b1;
    end
  end

  // Next state and pause counter; a new-game edge overrides everything else.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (ng_edge) begin
      state_nx = S_PAUSE;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_PAUSE: begin
          if (cnt == CNT_LAST) begin
            state_nx = S_PLAY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_PLAY: begin
          if (goal_one) begin
            state_nx = p1_wins ? S_OVER : S_PAUSE;
            cnt_nx   = '0;
          end else if (goal_two) begin
            state_nx = p2_wins ? S_OVER : S_PAUSE;
            cnt_nx   = '0;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  // Next values of the registered outputs: scoring, win flags, serve pulse and direction.
  always_comb begin
    score1_nx = Score1;
    score2_nx = Score2;
    win1_nx   = WIN1;
    win2_nx   = WIN2;
    dir_nx    = SERVE_DIR;
    paused_nx = (state_nx == S_PAUSE);
    serve_nx  = (state == S_PAUSE) && (state_nx == S_PLAY);
    if (ng_edge) begin
      score1_nx = '0;
      score2_nx = '0;
      win1_nx   = 1'b0;
      win2_nx   = 1'b0;
      dir_nx    = 1'b0;
    end else if (state == S_PLAY) begin
      if (goal_one) begin
        score1_nx = inc1;
        dir_nx    = 1'b1;
        win1_nx   = p1_wins;
      end else if (goal_two) begin
        score2_nx = inc2;
        dir_nx    = 1'b0;
        win2_nx   = p2_wins;
      end
    end
  end

endmodule
